dbus_responder: RTL
===================

DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 64-bit memory words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, idle cycles between acceptance and response (0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 64'h8000_0000, byte address of word 0.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port req_valid  in  1  core data-bus request present.
REQ-007 SHALL have port req_addr  in  64  byte address.
REQ-008 SHALL have port req_strobe  in  8  byte write enables; 0 = read.
REQ-009 SHALL have port req_data  in  64  write data, byte lanes aligned to addr[2:0]=0.
REQ-010 SHALL have port resp_addr_ok  out  1  request accepted this cycle.
REQ-011 SHALL have port resp_data_ok  out  1  response valid this cycle.
REQ-012 SHALL have port resp_data  out  64  read data (pre-write word).
REQ-013 SHALL have port err  out  1  sticky out-of-range flag.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE, resp_addr_ok SHALL equal req_valid (combinational); on req_valid, latch addr, strobe, data and load counter with LATENCY.
REQ-016 From IDLE on acceptance: LATENCY=0 -> RESP next cycle; else -> WAIT.
REQ-017 In WAIT, counter SHALL decrement each cycle; transition to RESP on the cycle after counter reaches 1 (exactly LATENCY WAIT cycles).
REQ-018 In RESP, resp_data_ok SHALL be 1 for exactly one cycle, then -> IDLE; no new acceptance in RESP.
REQ-019 Acceptance-to-data_ok latency SHALL be LATENCY+1 cycles; back-to-back throughput one transaction per LATENCY+2 cycles.
REQ-020 Word index SHALL be (addr-BASE_ADDR)>>3, width log2(DEPTH_WORDS); addr[2:0] ignored.
REQ-021 resp_data SHALL be the word contents before any write of this transaction; resp_data SHALL be 0 outside RESP.
REQ-022 Writes SHALL commit in the RESP cycle, byte lane i updated iff strobe[i]=1; other lanes unchanged.
REQ-023 Address below BASE_ADDR or at/above BASE_ADDR+8*DEPTH_WORDS SHALL be out of range: read returns 0, write dropped, err set to 1 in RESP, handshake unchanged.
REQ-024 err SHALL stay 1 until reset.
REQ-025 req_valid or request fields changing after acceptance SHALL not affect the in-flight transaction.
REQ-026 resp_addr_ok SHALL be 0 in WAIT and RESP regardless of req_valid.
REQ-027 Memory array SHALL not be cleared by reset; contents are undefined until written.

Reset
REQ-028 While reset=0: state IDLE, counter 0, latched fields 0, err 0; resp_data_ok 0, resp_data 0, resp_addr_ok follows REQ-015 only after reset deasserts (0 during reset).
REQ-029 Reset asserted mid-transaction SHALL abort it immediately: no data_ok, no write commit.
REQ-030 First acceptance SHALL be possible on the first rising edge with reset=1.

Verification
REQ-031 LATENCY=2: write addr 0x8000_0008 strobe 0xFF data 0x1122334455667788 -> addr_ok at cycle 0, data_ok at cycle 3; then read same addr -> resp_data 0x1122334455667788.
REQ-032 Partial write strobe 0x0F data 0xAAAAAAAA_BBBBBBBB over 0x1122334455667788 -> subsequent read 0x11223344_BBBBBBBB; the write's own resp_data 0x1122334455667788.
REQ-033 LATENCY=0: read held valid continuously -> addr_ok every 2nd cycle, data_ok cycle after each acceptance.
REQ-034 Read addr 0x7FFF_FFF8 and write addr 0x8000_2000 (DEPTH 1024) -> resp_data 0, err=1 stays set, memory word 0 unchanged.
REQ-035 Reset asserted in WAIT of a write -> no data_ok; after release, read same addr returns prior value; err 0.
REQ-036 Drop req_valid and change req_addr in WAIT -> data_ok still at scheduled cycle with data of originally latched address.

Source files
------------

// File: rtl/dbus_responder.sv
// Data-bus responder: fixed-latency single-port memory model.
// One request in flight; addr_ok on accept, data_ok LATENCY+1 later.
module dbus_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  strb_q, strb_d;
  logic [63:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH_WORDS];

  logic [63:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          in_resp;
  logic          accept;
  logic [63:0]   rd_word;
  logic [63:0]   wr_word;

  // Decode the latched address and merge strobed lanes over the old word.
  always_comb begin
    off      = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && (off < SPAN);
    idx      = off[AW+2:3];
    in_resp  = (state_q == S_RESP);
    accept   = reset && (state_q == S_IDLE) && req_valid;
    rd_word  = mem[idx];
    wr_word  = rd_word;
    for (int i = 0; i < 8; i++) begin
      if (strb_q[i]) wr_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  assign resp_addr_ok = accept;
  assign resp_data_ok = in_resp;
  assign resp_data    = (in_resp && in_range) ? rd_word : '0;
  assign err          = err_q | (in_resp & ~in_range);

  // Handshake FSM with latency countdown and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    err_d   = err_q | (in_resp & ~in_range);
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (req_valid) begin
          addr_d  = req_addr;
          strb_d  = req_strobe;
          wdata_d = req_data;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      (state_q == S_WAIT): begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      (state_q == S_RESP): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and captured-request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; a write lands on the RESP edge only.
  always_ff @(posedge clk) begin
    if (reset && in_resp && in_range) begin
      mem[idx] <= wr_word;
    end
  end

endmodule
